// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// RX is resynchronized and sampled mid-bit using a half-period initial count.
module uart_txrx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data
);

    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

    tx_state_t r_tx_state;
    tx_state_t w_tx_next;
    logic [9:0]    r_tx_shift;
    logic [CW-1:0] r_tx_baud;
    logic [3:0]    r_tx_bits;
    logic          r_tx_done;
    logic          w_tx_load;
    logic          w_tx_bit_end;
    logic          w_tx_last;

    assign w_tx_bit_end = (r_tx_baud == CW'(BAUD_DIV - 1));
    assign w_tx_last    = w_tx_bit_end && (r_tx_bits == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_load = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (trmt) begin
                    w_tx_next = TX_XMIT;
                    w_tx_load = 1'b1;
                end
            end
            TX_XMIT: begin
                if (w_tx_last) w_tx_next = TX_IDLE;
            end
        endcase
    end

    // Idle shift register is all ones, so TX (its LSB) idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_shift <= {1'b1, tx_data, 1'b0};
            r_tx_baud  <= '0;
            r_tx_bits  <= '0;
            r_tx_done  <= 1'b0;
        end else if (r_tx_state == TX_XMIT) begin
            if (w_tx_bit_end) begin
                r_tx_baud  <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                r_tx_bits  <= r_tx_bits + 4'd1;
                if (w_tx_last) r_tx_done <= 1'b1;
            end else begin
                r_tx_baud <= r_tx_baud + CW'(1);
            end
        end
    end

    assign TX      = r_tx_shift[0];
    assign tx_done = r_tx_done;

    rx_state_t r_rx_state;
    rx_state_t w_rx_next;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic [CW-1:0] r_rx_baud;
    logic [3:0]    r_rx_bits;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_data;
    logic          r_rdy;
    logic          w_rx_start;
    logic          w_rx_samp;
    logic          w_rx_stop;
    logic          w_rx_data_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= RX;
            r_rx_s2 <= r_rx_s1;
        end
    end

    assign w_rx_start    = (r_rx_state == RX_IDLE) && !r_rx_s2;
    assign w_rx_samp     = (r_rx_state == RX_RECV) && (r_rx_baud == '0);
    assign w_rx_stop     = w_rx_samp && (r_rx_bits == 4'd9);
    assign w_rx_data_bit = (r_rx_bits != 4'd0) && (r_rx_bits != 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_s2) w_rx_next = RX_RECV;
            end
            RX_RECV: begin
                if (w_rx_stop) w_rx_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else if (w_rx_start) begin
            r_rx_baud <= CW'(BAUD_DIV / 2);
            r_rx_bits <= '0;
        end else if (w_rx_samp) begin
            r_rx_baud <= CW'(BAUD_DIV - 1);
            r_rx_bits <= r_rx_bits + 4'd1;
            if (w_rx_data_bit) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (w_rx_stop)     r_rx_data  <= r_rx_shift;
        end else if (r_rx_state == RX_RECV) begin
            r_rx_baud <= r_rx_baud - CW'(1);
        end
    end

    // Setting rdy takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_rdy <= 1'b0;
        else if (w_rx_stop)             r_rdy <= 1'b1;
        else if (clr_rdy || w_rx_start) r_rdy <= 1'b0;
    end

    assign rdy     = r_rdy;
    assign rx_data = r_rx_data;

endmodule

// File: tb/tb_uart_txrx.sv
// Loopback bench for uart_txrx: random bytes checked against a frame-level model.
module tb_uart_txrx;

    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt = 1'b0;
    logic       clr_rdy = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       w_tx;
    logic       w_tx_done;
    logic       w_rdy;
    logic [7:0] w_rx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_txrx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (w_tx),
        .tx_done (w_tx_done),
        .RX      (w_tx),
        .clr_rdy (clr_rdy),
        .rdy     (w_rdy),
        .rx_data (w_rx_data)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Bit idx of an 8N1 frame: start, data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    // Called at a negedge; t counts rising edges after the trmt edge.
    task automatic send(input logic [7:0] d, input int mid,
                        output int nbad, output int rise_t,
                        output int lowrun, output logic [7:0] cap);
        int  run;
        bit  seen_low;
        logic exp_tx;
        nbad = 0; rise_t = -1; lowrun = 0; run = 0;
        seen_low = 0; cap = 8'h00;
        trmt = 1'b1;
        tx_data = d;
        @(posedge clk);
        for (int t = 0; t <= 10*B; t++) begin
            @(negedge clk);
            trmt = (t == mid);
            tx_data = 8'($urandom);
            exp_tx = (t < 10*B) ? frame_bit(d, t / B) : 1'b1;
            if (w_tx !== exp_tx) nbad++;
            if (w_tx_done !== (t >= 10*B)) nbad++;
            if (w_tx === 1'b0) begin
                run++;
                if (run > lowrun) lowrun = run;
            end else begin
                run = 0;
            end
            if (!w_rdy) seen_low = 1;
            else if (seen_low && rise_t < 0) begin
                rise_t = t;
                cap = w_rx_data;
            end
        end
        trmt = 1'b0;
    endtask

    task automatic frame(input logic [7:0] d, input int mid,
                         output int lowrun);
        int nbad;
        int rise_t;
        logic [7:0] cap;
        send(d, mid, nbad, rise_t, lowrun, cap);
        check("tx_wave", nbad, 0);
        check("rdy_window", (rise_t >= 9*B) && (rise_t < 10*B), 1);
        check("rx_byte", cap, d);
        check("rx_data_end", w_rx_data, d);
        check("tx_done_end", w_tx_done, 1);
    endtask

    initial begin
        int lr;
        logic [7:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", w_tx, 1);
        check("rst_done", w_tx_done, 0);
        check("rst_rdy", w_rdy, 0);
        check("rst_rxd", w_rx_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        frame(8'h75, -1, lr);
        repeat (50) @(negedge clk);
        check("hold_rdy", w_rdy, 1);
        check("hold_rxd", w_rx_data, 8'h75);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("clr_rdy", w_rdy, 0);
        check("clr_keeps_rxd", w_rx_data, 8'h75);

        frame(8'h00, -1, lr);
        check("low_run_00", lr, 9*B);
        frame(8'hFF, -1, lr);
        check("low_run_ff", lr, B);
        frame(8'h3C, 5*B + 3, lr);

        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            frame(d, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10*B - 2)) : -1, lr);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
                check("rand_clr", w_rdy, 0);
            end
        end

        trmt = 1'b1;
        tx_data = 8'h5A;
        @(negedge clk);
        trmt = 1'b0;
        repeat (4*B) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", w_tx, 1);
        check("mid_rst_done", w_tx_done, 0);
        check("mid_rst_rdy", w_rdy, 0);
        check("mid_rst_rxd", w_rx_data, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_hold_tx", w_tx, 1);
        rst_n = 1'b1;
        repeat (2*B) @(negedge clk);
        check("post_rst_rdy", w_rdy, 0);
        check("post_rst_tx", w_tx, 1);
        frame(8'hA5, -1, lr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
